// File: rtl/seven_seg_scan_driver_if.sv
// Display bus between the clock counter core (master) and the seven-segment scan driver (slave).
interface seven_seg_scan_driver_if #(
   parameter int NUM_FIELDS = 2
);
   logic [7*NUM_FIELDS-1:0]  field_bin;
   logic                     update;
   logic [NUM_FIELDS-1:0]    blink_mask;
   logic                     lz_blank;
   logic                     busy;
   logic [14*NUM_FIELDS-1:0] seg_static;
   logic [6:0]               seg_mux;
   logic [2*NUM_FIELDS-1:0]  digit_en;

   modport master (
      output field_bin, update, blink_mask, lz_blank,
      input  busy, seg_static, seg_mux, digit_en
   );

   modport slave (
      input  field_bin, update, blink_mask, lz_blank,
      output busy, seg_static, seg_mux, digit_en
   );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Sequential binary-to-BCD display driver: shift-add-3 per field, atomic commit with a
// one-deep pending buffer, live blink / leading-zero blanking, static and scanned outputs.
module seven_seg_scan_driver #(
   parameter int NUM_FIELDS = 2,
   parameter int SCAN_DIV   = 50000,
   parameter int BLINK_DIV  = 12500000,
   parameter int ACTIVE_LOW = 1
) (
   input logic clk,
   input logic rst_n,
   seven_seg_scan_driver_if.slave bus
);
   localparam int ND = 2 * NUM_FIELDS;
   localparam int FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
   localparam int DW = $clog2(ND);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [3:0] CODE_DASH  = 4'hE;
   localparam logic [3:0] CODE_BLANK = 4'hF;
   localparam logic [6:0] SEG_BLANK  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   state_t                        state_q, state_d;
   logic [7*NUM_FIELDS-1:0]       shadow, pend_val, restart_val;
   logic                          pending, restart;
   logic [6:0]                    sh_bin;
   logic [7:0]                    bcd;
   logic [8:0]                    bcd_nx;
   logic [FW-1:0]                 fld_idx, nxt_idx;
   logic [2:0]                    bit_cnt;
   logic                          last_step, last_field;
   logic [NUM_FIELDS-1:0][7:0]    stage_bcd;
   logic [NUM_FIELDS-1:0]         stage_ovf;
   logic [ND-1:0][3:0]            disp_code;
   logic [ND-1:0][6:0]            dig_seg;
   logic [SW-1:0]                 scan_cnt;
   logic [DW-1:0]                 scan_idx, scan_nxt;
   logic                          scan_wrap;
   logic [ND-1:0]                 digit_en;
   logic [6:0]                    seg_mux;
   logic [BW-1:0]                 blink_cnt;
   logic                          phase;   // 1 = blinking fields hidden

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] c);
      case (c)
         4'd0: glyph = 7'h3F;  4'd1: glyph = 7'h06;  4'd2: glyph = 7'h5B;
         4'd3: glyph = 7'h4F;  4'd4: glyph = 7'h66;  4'd5: glyph = 7'h6D;
         4'd6: glyph = 7'h7D;  4'd7: glyph = 7'h07;  4'd8: glyph = 7'h7F;
         4'd9: glyph = 7'h6F;  CODE_DASH: glyph = 7'h40;
         default: glyph = 7'h00;
      endcase
   endfunction

   // The ninth bit is the hundreds carry of the final step; only values >99 produce it.
   assign bcd_nx      = {add3(bcd[7:4]), add3(bcd[3:0]), sh_bin[6]};
   assign last_step   = (bit_cnt == 3'd6);
   assign last_field  = (fld_idx == FW'(NUM_FIELDS - 1));
   assign nxt_idx     = last_field ? '0 : fld_idx + 1'b1;
   assign restart     = pending | bus.update;
   assign restart_val = bus.update ? bus.field_bin : pend_val;
   assign bus.busy    = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.update) state_d = CONV;
         CONV:    if (last_step && last_field) state_d = COMMIT;
         COMMIT:  state_d = restart ? CONV : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shadow    <= '0;
         pend_val  <= '0;
         pending   <= 1'b0;
         sh_bin    <= '0;
         bcd       <= '0;
         fld_idx   <= '0;
         bit_cnt   <= '0;
         stage_bcd <= '0;
         stage_ovf <= '0;
         disp_code <= {ND{CODE_BLANK}};
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (bus.update) begin
               shadow  <= bus.field_bin;
               sh_bin  <= bus.field_bin[6:0];
               bcd     <= '0;
               fld_idx <= '0;
               bit_cnt <= '0;
            end
            CONV: begin
               if (bus.update) begin
                  pend_val <= bus.field_bin;
                  pending  <= 1'b1;
               end
               if (last_step) begin
                  stage_bcd[fld_idx] <= bcd_nx[7:0];
                  stage_ovf[fld_idx] <= bcd_nx[8];
                  fld_idx <= nxt_idx;
                  bit_cnt <= '0;
                  sh_bin  <= shadow[nxt_idx*7 +: 7];
                  bcd     <= '0;
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  sh_bin  <= {sh_bin[5:0], 1'b0};
                  bcd     <= bcd_nx[7:0];
               end
            end
            COMMIT: begin
               for (int i = 0; i < NUM_FIELDS; i++) begin
                  disp_code[2*i]   <= stage_ovf[i] ? CODE_DASH : stage_bcd[i][3:0];
                  disp_code[2*i+1] <= stage_ovf[i] ? CODE_DASH : stage_bcd[i][7:4];
               end
               // An update landing on the commit cycle is folded in as the pending value.
               if (restart) begin
                  shadow  <= restart_val;
                  sh_bin  <= restart_val[6:0];
                  bcd     <= '0;
                  fld_idx <= '0;
                  bit_cnt <= '0;
               end
               pending <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Blink mask and leading-zero blanking act on the committed codes every cycle.
   always_comb begin
      dig_seg = '0;
      for (int d = 0; d < ND; d++) begin
         dig_seg[d] = glyph(disp_code[d]);
         if ((bus.blink_mask[d/2] && phase) ||
             ((d % 2) == 1 && bus.lz_blank && disp_code[d] == 4'd0))
            dig_seg[d] = 7'h00;
         if (ACTIVE_LOW != 0) dig_seg[d] = ~dig_seg[d];
      end
   end

   assign bus.seg_static = dig_seg;

   assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));
   assign scan_nxt  = !scan_wrap ? scan_idx :
                      (scan_idx == DW'(ND - 1)) ? '0 : scan_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt  <= '0;
         scan_idx  <= '0;
         digit_en  <= ND'(1);
         seg_mux   <= SEG_BLANK;
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else begin
         scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
         scan_idx <= scan_nxt;
         if (scan_wrap) digit_en <= {digit_en[ND-2:0], digit_en[ND-1]};
         seg_mux  <= dig_seg[scan_nxt];
         if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   assign bus.digit_en = digit_en;
   assign bus.seg_mux  = seg_mux;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench: commits are checked by a scoreboard monitor; scan, blink and reset by direct checks.
module tb_seven_seg_scan_driver;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   seven_seg_scan_driver_if #(.NUM_FIELDS(2)) bus();

   seven_seg_scan_driver #(
      .NUM_FIELDS(2), .SCAN_DIV(4), .BLINK_DIV(8), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [27:0] seg;
      int          len;
   } exp_t;

   exp_t sb[$];
   int   blen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string name, input logic [27:0] seg, input int len);
      exp_t e;
      e.name = name; e.seg = seg; e.len = len;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.busy && n < 100) begin
         tick();
         n++;
      end
      if (bus.busy) chk({name, "_timeout"}, 32'd1, 32'd0);
      tick();
   endtask

   task automatic send(input logic [6:0] f0, input logic [6:0] f1);
      bus.field_bin = {f1, f0};
      bus.update    = 1'b1;
      tick();
      bus.update    = 1'b0;
   endtask

   // Monitor: a busy falling edge marks a commit; compare against the oldest expectation.
   always @(negedge clk) begin
      if (!rst_n) begin
         blen = 0;
      end else if (bus.busy) begin
         blen++;
      end else if (blen > 0) begin
         if (sb.size() == 0) begin
            chk("unexpected_commit", 32'(blen), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_seg"}, 32'(bus.seg_static), 32'(e.seg));
            chk({e.name, "_busy_len"}, 32'(blen), 32'(e.len));
         end
         blen = 0;
      end
   end

   logic [6:0] exp_dig [4];

   initial begin
      bus.field_bin  = '0;
      bus.update     = 1'b0;
      bus.blink_mask = '0;
      bus.lz_blank   = 1'b0;
      exp_dig[0] = 7'h78; exp_dig[1] = 7'h30; exp_dig[2] = 7'h24; exp_dig[3] = 7'h79;

      repeat (3) tick();
      chk("rst_busy",     32'(bus.busy), 32'd0);
      chk("rst_static",   32'(bus.seg_static), 32'h0FFF_FFFF);
      chk("rst_mux",      32'(bus.seg_mux), 32'h7F);
      chk("rst_digit_en", 32'(bus.digit_en), 32'h1);

      // 37/12 with field 0 blinking; scan and blink phases counted from reset release.
      push("conv_37_12", {7'h79, 7'h24, 7'h30, 7'h78}, 15);
      bus.blink_mask = 2'b01;
      bus.field_bin  = {7'd12, 7'd37};
      bus.update     = 1'b1;
      rst_n          = 1'b1;
      chk("pre_commit_blank", 32'(bus.seg_static), 32'h0FFF_FFFF);
      for (int k = 1; k <= 48; k++) begin
         tick();
         if (k == 1) bus.update = 1'b0;
         chk("digit_en", 32'(bus.digit_en), 32'(4'b0001 << ((k / 4) % 4)));
         if (k == 8) chk("blank_before_commit", 32'(bus.seg_static), 32'h0FFF_FFFF);
         if (k >= 17) begin
            logic hs, hm;
            int   d;
            hs = ((k / 8) % 2) == 1;
            hm = (((k - 1) / 8) % 2) == 1;
            d  = (k / 4) % 4;
            chk("blink_static", 32'(bus.seg_static),
                32'({7'h79, 7'h24, hs ? 7'h7F : 7'h30, hs ? 7'h7F : 7'h78}));
            chk("blink_mux", 32'(bus.seg_mux),
                32'((d < 2 && hm) ? 7'h7F : exp_dig[d]));
         end
      end
      bus.blink_mask = '0;
      tick();

      // Leading-zero blanking, then live removal of it.
      bus.lz_blank = 1'b1;
      push("conv_5_0_lz", {7'h7F, 7'h40, 7'h7F, 7'h12}, 15);
      send(7'd5, 7'd0);
      wait_idle("conv_5_0_lz");
      bus.lz_blank = 1'b0;
      tick();
      chk("lz_off_live", 32'(bus.seg_static), 32'({7'h40, 7'h40, 7'h40, 7'h12}));

      // Overflow on field 0 only.
      push("conv_120_45", {7'h19, 7'h12, 7'h3F, 7'h3F}, 15);
      send(7'd120, 7'd45);
      wait_idle("conv_120_45");

      // Back-to-back: 10/10 commits, 22/33 is overwritten by 44/55.
      push("conv_44_55", {7'h12, 7'h12, 7'h19, 7'h19}, 30);
      send(7'd10, 7'd10);
      repeat (2) tick();
      send(7'd22, 7'd33);
      repeat (4) tick();
      send(7'd44, 7'd55);
      repeat (11) tick();
      chk("mid_10_10", 32'(bus.seg_static), 32'({7'h79, 7'h40, 7'h79, 7'h40}));
      wait_idle("conv_44_55");

      // Reset five cycles into a conversion.
      send(7'd99, 7'd98);
      repeat (4) tick();
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_busy",   32'(bus.busy), 32'd0);
      chk("async_rst_static", 32'(bus.seg_static), 32'h0FFF_FFFF);
      chk("async_rst_mux",    32'(bus.seg_mux), 32'h7F);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      chk("post_rst_busy",   32'(bus.busy), 32'd0);
      chk("post_rst_static", 32'(bus.seg_static), 32'h0FFF_FFFF);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
